// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the pipeline control unit.
// The datapath side is the master; the controller consumes hazard inputs and returns stall/flush.
interface pipe_ctrl_if #(
    parameter int MRLen = 6,
    parameter int CntW  = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             ex_is_load;
    logic [4:0]       ex_rd;
    logic             ex_redirect;
    logic             ex_mdu_start;
    logic             mem_req;
    logic             mem_ready;
    logic             halt;
    logic             pc_stall;
    logic [MRLen-2:0] stall;
    logic [MRLen-2:0] flush;
    logic             mdu_busy;
    logic [CntW-1:0]  stall_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_is_load, ex_rd,
               ex_redirect, ex_mdu_start, mem_req, mem_ready, halt,
        input  pc_stall, stall, flush, mdu_busy, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_is_load, ex_rd,
               ex_redirect, ex_mdu_start, mem_req, mem_ready, halt,
        output pc_stall, stall, flush, mdu_busy, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: merges load-use, memory-wait, MDU and halt hold requests into a
// prefix stall vector, squashes wrong-path slots on EX redirects and counts PC stall cycles.
module pipe_ctrl #(
    parameter int MRLen  = 6,
    parameter int MduLat = 4,
    parameter int CntW   = 32
) (
    input  logic       clk,
    input  logic       grst_n,
    pipe_ctrl_if.slave bus
);
    localparam int SW = MRLen - 1;
    localparam int MW = (MduLat > 1) ? $clog2(MduLat) : 1;
    localparam logic [MW-1:0] MduLoad = MW'(MduLat - 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, MDU_WAIT} state_t;

    state_t          state;
    logic [MW-1:0]   mdu_cnt;
    logic [CntW-1:0] stall_cnt;

    logic          load_use;
    logic          mem_wait;
    logic          mdu_hold;
    logic          hold_ex;
    logic          redirect_ok;
    logic          mdu_load;
    logic [MW-1:0] mdu_next;
    logic [SW-1:0] stall_v;
    logic [SW-1:0] flush_v;

    // Once MEM_WAIT is entered only mem_ready releases it; hold_ex equals stall[1].
    always_comb begin
        load_use = bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                   ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                    (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
        mem_wait = (state == MEM_WAIT) ? !bus.mem_ready : (bus.mem_req && !bus.mem_ready);
        mdu_hold = (mdu_cnt != '0);
        hold_ex = bus.halt || mem_wait || mdu_hold;
        redirect_ok = bus.ex_redirect && !hold_ex;
        mdu_load = bus.ex_mdu_start && !hold_ex;

        mdu_next = '0;
        if (mdu_load) begin
            mdu_next = MduLoad;
        end else if (mdu_hold) begin
            mdu_next = mdu_cnt - MW'(1);
        end

        stall_v = '0;
        for (int i = 0; i < SW; i++) begin
            stall_v[i] = grst_n && (bus.halt ||
                                    ((i <= 2) && mem_wait) ||
                                    ((i <= 1) && mdu_hold) ||
                                    ((i == 0) && load_use && !redirect_ok));
        end

        flush_v = '0;
        flush_v[1:0] = {2{grst_n && redirect_ok}};
    end

    // Halt freezes both the FSM and the MDU countdown; the stall counter keeps running.
    always_ff @(posedge clk or negedge grst_n) begin
        if (!grst_n) begin
            state     <= RUN;
            mdu_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (!bus.halt) begin
                mdu_cnt <= mdu_next;
                if (mem_wait) begin
                    state <= MEM_WAIT;
                end else if (mdu_next != '0) begin
                    state <= MDU_WAIT;
                end else begin
                    state <= RUN;
                end
            end
            if (stall_v[0] && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CntW'(1);
            end
        end
    end

    assign bus.stall     = stall_v;
    assign bus.flush     = flush_v;
    assign bus.pc_stall  = stall_v[0];
    assign bus.mdu_busy  = mdu_hold;
    assign bus.stall_cnt = stall_cnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed hazard scenarios and randomized traffic, checked against
// a depth-based reference model; a second small instance covers MduLat=1 and counter saturation.
`timescale 1ns/1ps
module tb_pipe_ctrl;
    localparam int MRLen  = 6;
    localparam int MduLat = 4;
    localparam int CntW   = 32;

    typedef struct packed {
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       id_use_rs1;
        logic       id_use_rs2;
        logic       ex_is_load;
        logic [4:0] ex_rd;
        logic       ex_redirect;
        logic       ex_mdu_start;
        logic       mem_req;
        logic       mem_ready;
        logic       halt;
    } stim_t;

    logic clk = 1'b0;
    logic grst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.MRLen(MRLen), .CntW(CntW)) bus ();
    pipe_ctrl_if #(.MRLen(MRLen), .CntW(3))    sbus ();

    pipe_ctrl #(.MRLen(MRLen), .MduLat(MduLat), .CntW(CntW)) dut (
        .clk(clk), .grst_n(grst_n), .bus(bus)
    );
    pipe_ctrl #(.MRLen(MRLen), .MduLat(1), .CntW(3)) dut_small (
        .clk(clk), .grst_n(grst_n), .bus(sbus)
    );

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;

    stim_t cur;
    bit    m_in_wait;
    int    m_mdu_left;
    longint m_cnt;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_in_wait = 1'b0;
        m_mdu_left = 0;
        m_cnt = 0;
    endtask

    task automatic apply_stimulus(input stim_t s);
        cur = s;
        bus.id_rs1 = s.id_rs1;
        bus.id_rs2 = s.id_rs2;
        bus.id_use_rs1 = s.id_use_rs1;
        bus.id_use_rs2 = s.id_use_rs2;
        bus.ex_is_load = s.ex_is_load;
        bus.ex_rd = s.ex_rd;
        bus.ex_redirect = s.ex_redirect;
        bus.ex_mdu_start = s.ex_mdu_start;
        bus.mem_req = s.mem_req;
        bus.mem_ready = s.mem_ready;
        bus.halt = s.halt;
        #2;
    endtask

    // Expected outputs follow from the deepest requested hold; then advance one clock.
    task automatic check_output(input string name);
        bit lu, mem_w, redir;
        int depth;
        int e_stall;
        lu = cur.ex_is_load && (cur.ex_rd != 5'd0) &&
             ((cur.id_use_rs1 && cur.id_rs1 == cur.ex_rd) ||
              (cur.id_use_rs2 && cur.id_rs2 == cur.ex_rd));
        mem_w = m_in_wait ? !cur.mem_ready : (cur.mem_req && !cur.mem_ready);
        depth = -1;
        if (lu) depth = 0;
        if (m_mdu_left > 0) depth = 1;
        if (mem_w) depth = 2;
        if (cur.halt) depth = MRLen - 2;
        redir = cur.ex_redirect && (depth < 1);
        if (redir) depth = -1;
        e_stall = (1 << (depth + 1)) - 1;

        check_val({name, ".stall"}, 64'(bus.stall), 64'(e_stall));
        check_val({name, ".flush"}, 64'(bus.flush), redir ? 64'd3 : 64'd0);
        check_val({name, ".pc_stall"}, 64'(bus.pc_stall), 64'(depth >= 0));
        check_val({name, ".mdu_busy"}, 64'(bus.mdu_busy), 64'(m_mdu_left > 0));
        check_val({name, ".stall_cnt"}, 64'(bus.stall_cnt), 64'(m_cnt));

        if (depth >= 0 && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (!cur.halt) begin
            m_in_wait = mem_w;
            if (cur.ex_mdu_start && depth < 1) m_mdu_left = MduLat - 1;
            else if (m_mdu_left > 0) m_mdu_left--;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        stim_t s;
        longint c0;

        sbus.id_rs1 = '0;
        sbus.id_rs2 = '0;
        sbus.id_use_rs1 = 1'b0;
        sbus.id_use_rs2 = 1'b0;
        sbus.ex_is_load = 1'b0;
        sbus.ex_rd = '0;
        sbus.ex_redirect = 1'b0;
        sbus.ex_mdu_start = 1'b0;
        sbus.mem_req = 1'b0;
        sbus.mem_ready = 1'b0;
        sbus.halt = 1'b0;
        model_reset();
        apply_stimulus(idle());
        #1;
        check_val("reset.stall", 64'(bus.stall), 64'd0);
        check_val("reset.flush", 64'(bus.flush), 64'd0);
        check_val("reset.pc_stall", 64'(bus.pc_stall), 64'd0);
        check_val("reset.mdu_busy", 64'(bus.mdu_busy), 64'd0);
        check_val("reset.stall_cnt", 64'(bus.stall_cnt), 64'd0);
        #9 grst_n = 1'b1;
        @(posedge clk);
        #1;

        s = idle();
        s.ex_is_load = 1'b1; s.ex_rd = 5'd5; s.id_rs1 = 5'd5; s.id_use_rs1 = 1'b1;
        apply_stimulus(s);
        check_val("lu.stall_direct", 64'(bus.stall), 64'h01);
        check_output("lu");
        s.ex_rd = 5'd0; s.id_rs1 = 5'd0;
        apply_stimulus(s);
        check_output("lu_rd0");
        s = idle();
        s.ex_is_load = 1'b1; s.ex_rd = 5'd7; s.id_rs2 = 5'd7; s.id_use_rs2 = 1'b1;
        apply_stimulus(s);
        check_output("lu_rs2");

        c0 = m_cnt;
        s = idle();
        s.mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(s);
            check_val("memwait.stall_direct", 64'(bus.stall), 64'h07);
            check_output("memwait");
        end
        s.mem_ready = 1'b1;
        apply_stimulus(s);
        check_output("memready");
        apply_stimulus(idle());
        check_val("memwait.cnt_delta", 64'(bus.stall_cnt), 64'(c0 + 3));
        check_output("idle1");

        s = idle();
        s.ex_mdu_start = 1'b1;
        apply_stimulus(s);
        check_output("mdu_start");
        for (int i = 0; i < MduLat; i++) begin
            apply_stimulus(idle());
            check_output("mdu_run");
        end

        s = idle();
        s.ex_is_load = 1'b1; s.ex_rd = 5'd3; s.id_rs1 = 5'd3; s.id_use_rs1 = 1'b1;
        s.ex_redirect = 1'b1;
        apply_stimulus(s);
        check_val("redir_lu.flush_direct", 64'(bus.flush), 64'h03);
        check_output("redir_lu");

        s = idle();
        s.mem_req = 1'b1; s.ex_redirect = 1'b1;
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(s);
            check_output("redir_memwait");
        end
        s.mem_ready = 1'b1;
        apply_stimulus(s);
        check_val("redir_memready.flush_direct", 64'(bus.flush), 64'h03);
        check_output("redir_memready");

        s = idle();
        s.ex_mdu_start = 1'b1;
        apply_stimulus(s);
        check_output("rst_mdu_start");
        apply_stimulus(idle());
        check_val("rst_mdu.busy_before", 64'(bus.mdu_busy), 64'd1);
        grst_n = 1'b0;
        #1;
        model_reset();
        check_val("rst_mid.stall", 64'(bus.stall), 64'd0);
        check_val("rst_mid.mdu_busy", 64'(bus.mdu_busy), 64'd0);
        check_val("rst_mid.stall_cnt", 64'(bus.stall_cnt), 64'd0);
        @(negedge clk);
        grst_n = 1'b1;
        @(posedge clk);
        #1;
        s = idle();
        s.ex_is_load = 1'b1; s.ex_rd = 5'd9; s.id_rs1 = 5'd9; s.id_use_rs1 = 1'b1;
        apply_stimulus(s);
        check_output("post_rst_lu");
        apply_stimulus(idle());
        check_output("post_rst_idle");

        for (int n = 0; n < 400; n++) begin
            s = idle();
            s.id_rs1 = 5'($urandom_range(0, 3));
            s.id_rs2 = 5'($urandom_range(0, 3));
            s.id_use_rs1 = ($urandom_range(0, 1) == 0);
            s.id_use_rs2 = ($urandom_range(0, 1) == 0);
            s.ex_is_load = ($urandom_range(0, 2) == 0);
            s.ex_rd = 5'($urandom_range(0, 3));
            s.ex_redirect = ($urandom_range(0, 7) == 0);
            s.ex_mdu_start = ($urandom_range(0, 9) == 0);
            s.mem_req = m_in_wait ? 1'b1 : ($urandom_range(0, 3) == 0);
            s.mem_ready = ($urandom_range(0, 2) == 0);
            s.halt = ($urandom_range(0, 19) == 0);
            apply_stimulus(s);
            check_output("rand");
        end
        apply_stimulus(idle());

        sbus.ex_mdu_start = 1'b1;
        #2;
        check_val("small.start_stall", 64'(sbus.stall), 64'd0);
        @(posedge clk);
        #1;
        sbus.ex_mdu_start = 1'b0;
        #2;
        check_val("small.mdu_busy", 64'(sbus.mdu_busy), 64'd0);
        check_val("small.after_stall", 64'(sbus.stall), 64'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) begin
            sbus.halt = 1'b1;
            #2;
            check_val("small.halt_stall", 64'(sbus.stall), 64'h1F);
            check_val("small.halt_cnt", 64'(sbus.stall_cnt), 64'((i < 7) ? i : 7));
            @(posedge clk);
            #1;
        end
        sbus.halt = 1'b0;
        #2;
        check_val("small.cnt_saturated", 64'(sbus.stall_cnt), 64'd7);
        check_val("small.release", 64'(sbus.pc_stall), 64'd0);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline control unit that produces the per-slot stall/flush vectors consumed by the pipeline register buffers. Slot indices are 0=IF/ID, 1=ID/EX, 2=EX/MEM, 3=MEM/WB, 4=WB/retire.
The block detects load-use hazards, holds the pipe during data-memory wait and multi-cycle MDU operations, and squashes wrong-path slots on EX redirects. It also counts stall cycles for performance monitoring.

Parameters:
MRLen, 6, pipeline depth; stall/flush vectors have MRLen-1 entries.
MduLat, 4, MDU latency in cycles (>=1); 1 means no stall.
CntW, 32, width of stall-cycle counter.

Ports:
clk  in  1  clock
grst_n  in  1  reset, asynchronous, active-low
id_rs1, id_rs2  in  5 each  source registers of the instruction in slot 0
id_use_rs1, id_use_rs2  in  1 each  the respective source register is read
ex_is_load  in  1  instruction in slot 1 is a load
ex_rd  in  5  destination register of slot 1
ex_redirect  in  1  EX resolved a taken branch or mispredict
ex_mdu_start  in  1  slot 1 holds an MDU operation, first EX cycle
mem_req  in  1  MEM stage (slot 2) has a data access outstanding
mem_ready  in  1  data memory completes the access this cycle
halt  in  1  debug halt, freezes all slots
pc_stall  out  1  hold the PC register
stall  out  [MRLen-2:0]  bit i holds slot i
flush  out  [MRLen-2:0]  bit i zeroes slot i on next edge
mdu_busy  out  1  MDU countdown active
stall_cnt  out  CntW  cycles with pc_stall=1, saturating

Behaviour:
- State FSM: RUN, MEM_WAIT, MDU_WAIT. Reset: state=RUN, mdu counter=0, stall_cnt=0, and all outputs 0 (outputs are combinational from state and inputs).
- The stall vector is always a prefix: the deepest held slot k forces stall[0..k]=1 and pc_stall=1. The bubble into slot k+1 comes from the buffer (left neighbour stalled reads 0), so no flush is issued for it.
- Load-use: ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - Response: depth 0 for exactly one cycle.
  - No FSM state is involved.
- Memory wait:
  - In RUN, mem_req & !mem_ready gives depth 2 in the same cycle and moves to MEM_WAIT.
  - MEM_WAIT holds depth 2 while !mem_ready.
  - When mem_ready=1, stall deasserts in that cycle and the FSM returns to RUN (or goes to MDU_WAIT if the MDU counter is nonzero).
- MDU:
  - ex_mdu_start with stall[1]=0 loads the counter with MduLat-1. If that value is nonzero, enter MDU_WAIT.
  - Depth 1 is held while counter!=0; the counter decrements each cycle.
  - The cycle the counter reaches 0, stall is released and the FSM returns to RUN. Total EX residency is MduLat cycles.
  - mdu_busy = counter!=0.
- Combined depth = max of all active sources.
  - A mem wait arising during MDU_WAIT gives depth 2, and the MDU counter keeps decrementing.
  - halt gives depth MRLen-2 (all slots) and freezes the MDU counter and the FSM.
- Redirect:
  - Acted on only when stall[1]=0. Sets flush[0]=flush[1]=1 and pc_stall=0 (the PC loads the target).
  - It overrides a simultaneous load-use stall: stall[0] is forced to 0.
  - While stall[1]=1 it is ignored. ex_redirect is expected to stay high until EX advances.
- flush[2..MRLen-2] are always 0.
- stall_cnt increments on every cycle with pc_stall=1 and saturates at all-ones.
- Reset mid-operation: grst_n low returns the block to RUN, clears the counter, and zeroes outputs immediately (asynchronous).
- ex_rd=0 never triggers load-use.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle with stall=5'b00001, pc_stall=1, flush=0. With ex_rd=0 -> no stall.
- Mem wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> stall=5'b00111 for 3 cycles, 0 on the ready cycle; stall_cnt increases by 3.
- MDU, MduLat=4: one-cycle ex_mdu_start -> stall=5'b00011 for 3 cycles, mdu_busy high for 3 cycles, then RUN.
- Redirect plus load-use in the same cycle -> flush=5'b00011, stall=0, pc_stall=0.
- Redirect during MEM_WAIT -> flush=0 and stall=5'b00111 until mem_ready; once stall[1]=0, flush=5'b00011.
- Reset asserted mid-MDU_WAIT -> outputs 0 immediately, stall_cnt=0, and after release a fresh load-use stall behaves normally.
